stream_route_switch: RTL and testbench
======================================

// Module: stream_route_switch
// PURPOSE
//  - Parametrised N-input x M-output AXI-Stream route switch. Generalises the fixed 5-in/8-out inter-layer switch.
//  - Selects one input by ctrl_in_sel and forwards its beats to one output by ctrl_out_sel through a registered skid stage.
//  - Adds packet-atomic routing (route locked until end-of-packet), a route tag carried with each beat, illegal-select detection and a beat counter.
//  - Sits between the PE-array result streams and the width converters and DMA ports.
// PARAMETERS
//  NUM_IN      5     number of slave input streams (1..15)
//  NUM_OUT     8     number of master output streams (1..15)
//  DATA_W      1536  tdata width per stream
//  LAST_W      12    tlast side-band width per stream (carried unchanged)
//  PKT_MODE    1     1: route locked from first beat to EOP beat; 0: route re-evaluated every beat
//  CNT_W       16    beat counter width
// PORTS
//  clk           in   1                 clock
//  rst_n         in   1                 synchronous active-low reset
//  ctrl_in_sel   in   4                 1-based input index; 0 = idle
//  ctrl_out_sel  in   4                 1-based output index; 0 = idle
//  s_tdata       in   NUM_IN*DATA_W     input i occupies [i*DATA_W +: DATA_W]
//  s_tlast       in   NUM_IN*LAST_W     per-input tlast bus; EOP = |tlast of selected input
//  s_tvalid      in   NUM_IN            per-input valid
//  s_tready      out  NUM_IN            per-input ready; only the selected bit can be 1
//  m_tdata       out  DATA_W            shared output data
//  m_tlast       out  LAST_W            shared output tlast bus
//  m_tvalid      out  NUM_OUT           one-hot-or-zero output valid
//  m_tready      in   NUM_OUT           per-output ready
//  route_busy    out  1                 1 while in LOCKED state
//  err_sel       out  1                 1-cycle pulse on illegal select (index > NUM_IN or > NUM_OUT)
//  beat_cnt      out  CNT_W             accepted input beats, wraps modulo 2^CNT_W
//  beat_pulse    out  1                 1 in each cycle an input beat is accepted
// BEHAVIOUR
//  - Reset: clk and reset are rst_n (synchronous, active-low) and clk. On reset, state=IDLE, skid stage empty, s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, route_busy=0, err_sel=0, beat_cnt=0, beat_pulse=0.
//  - Route: in IDLE (or every cycle when PKT_MODE=0), the active route is (ctrl_in_sel, ctrl_out_sel).
//    - A route is legal when both fields are non-zero, in_sel<=NUM_IN and out_sel<=NUM_OUT.
//    - A zero field means idle: no transfer and no error.
//    - An out-of-range field means no transfer; err_sel pulses once per IDLE entry to the illegal value, not every cycle while it is held.
//  - Input handshake: s_tready[k] = legal & (k==in_sel-1) & skid_ready. Accept = s_tvalid[k] & s_tready[k]. beat_pulse = accept.
//  - FSM (PKT_MODE=1), two states:
//    - IDLE -> LOCKED on an accepted beat with EOP=0. The route is latched; ctrl is ignored while LOCKED.
//    - IDLE -> IDLE on an accepted beat with EOP=1 (single-beat packet).
//    - LOCKED -> IDLE on an accepted beat with EOP=1. route_busy = (state==LOCKED).
//    - With PKT_MODE=0 the FSM stays in IDLE.
//  - Skid stage: 2-entry buffer storing {out_idx, tlast, tdata}.
//    - skid_ready is registered (=~second entry valid). Full throughput of 1 beat/clk.
//    - Latency is 1 clk from input accept to m_tvalid.
//  - Output: m_tvalid[j] = head_valid & (head_out_idx==j). The head pops on m_tvalid[j] & m_tready[j].
//    - Ready of non-addressed outputs is ignored.
//    - m_tdata/m_tlast hold their value while not popped (AXIS stability).
//  - The out_idx tag travels with each beat, so a route change while beats are pending never redirects buffered data.
//  - Simultaneous push and pop with 1 entry held: occupancy stays 1 and data order is preserved.
//  - beat_cnt increments on accept and wraps from 2^CNT_W-1 to 0.
//  - Reset mid-packet drops all buffered beats and returns to IDLE with no EOP emitted.
// STRUCTURE
//  - Package stream_switch_pkg holds:
//    - enum sw_state_e {IDLE, LOCKED}
//    - localparam SEL_W = 4
//    - function sel_legal(sel, max)
//  - Sub-module axis_skid_buffer #(W) holds the 2-entry registered-ready buffer. This module instantiates it with W = DATA_W+LAST_W+SEL_W.
//  - The input mux is an AND-OR reduce over one-hot enables; there is no priority logic.
// TESTING
//  1. in_sel=3, out_sel=5, 4 beats with tlast=0,0,0,0x800 and m_tready[4]=1 -> m_tvalid=8'h10 for 4 consecutive clks starting 1 clk after first accept; beat_cnt=4; route_busy 1 from 2nd to 4th accept.
//  2. Same packet, with ctrl changed to in=1,out=2 after the 1st beat -> all 4 beats still exit on output 5 from input 3; output 2 stays idle until after EOP.
//  3. m_tready[4] held 0 for 5 clks mid-packet -> s_tready drops after 2 buffered beats; no beat is lost or duplicated; data order is intact when ready returns.
//  4. ctrl_in_sel=7 (NUM_IN=5) held 10 clks -> err_sel high exactly 1 clk; no s_tready asserted; m_tvalid=0.
//  5. rst_n=0 for 1 clk during beat 2 of 4 -> m_tvalid=0 and beat_cnt=0 next clk; FSM in IDLE accepts a new route immediately.
//  6. PKT_MODE=0, route toggles between outputs 1 and 2 every beat with continuous valid -> beats alternate m_tvalid=8'h01 and 8'h02 at 1 beat/clk.

Source files
------------

// File: rtl/stream_route_switch_pkg.sv
// Shared types and helpers for the N-in x M-out stream route switch.
// Select fields are 1-based; zero means idle.
package stream_switch_pkg;

    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sw_state_e;

    // A select is usable when it names an existing port (1..max_sel).
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel, input int max_sel);
        return (sel != '0) && (32'(sel) <= 32'(max_sel));
    endfunction

endpackage

// File: rtl/stream_route_switch_if.sv
// Bundle of the switch's control, stream and status signals.
// "slave" is the switch side, "master" the surrounding fabric.
interface stream_route_switch_if
    import stream_switch_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int NUM_OUT = 8,
    parameter int DATA_W  = 1536,
    parameter int LAST_W  = 12,
    parameter int CNT_W   = 16
);
    logic [SEL_W-1:0]         ctrl_in_sel;
    logic [SEL_W-1:0]         ctrl_out_sel;
    logic [NUM_IN*DATA_W-1:0] s_tdata;
    logic [NUM_IN*LAST_W-1:0] s_tlast;
    logic [NUM_IN-1:0]        s_tvalid;
    logic [NUM_IN-1:0]        s_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic [LAST_W-1:0]        m_tlast;
    logic [NUM_OUT-1:0]       m_tvalid;
    logic [NUM_OUT-1:0]       m_tready;
    logic                     route_busy;
    logic                     err_sel;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     beat_pulse;

    modport slave (
        input  ctrl_in_sel, ctrl_out_sel, s_tdata, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tlast, m_tvalid, route_busy, err_sel, beat_cnt, beat_pulse
    );

    modport master (
        output ctrl_in_sel, ctrl_out_sel, s_tdata, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tlast, m_tvalid, route_busy, err_sel, beat_cnt, beat_pulse
    );

endinterface

// File: rtl/stream_route_switch_skid.sv
// Two-entry skid buffer with a registered input ready; 1 beat/clk,
// one cycle from push to out_valid, order always preserved.
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] head_q, head_d, skid_q, skid_d;
    logic         head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
    logic         ready_q, ready_d;
    logic         push, pop;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        push       = in_valid & ready_q;
        pop        = head_vld_q & out_ready;
        if (pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (push) begin
                head_d = in_data;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (head_vld_q) begin
                skid_d     = in_data;
                skid_vld_d = 1'b1;
            end else begin
                head_d     = in_data;
                head_vld_d = 1'b1;
            end
        end
        ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, because the output bus must read zero after reset.
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = head_q;
    assign out_valid = head_vld_q;

endmodule

// File: rtl/stream_route_switch.sv
// N-in x M-out stream route switch: one input forwarded to one output through a
// skid stage, with packet-atomic route locking, illegal-select pulse and beat counter.
module stream_route_switch
    import stream_switch_pkg::*;
#(
    parameter int NUM_IN   = 5,
    parameter int NUM_OUT  = 8,
    parameter int DATA_W   = 1536,
    parameter int LAST_W   = 12,
    parameter int PKT_MODE = 1,
    parameter int CNT_W    = 16
) (
    input logic clk,
    input logic rst_n,
    stream_route_switch_if.slave bus
);
    localparam int SKID_W = DATA_W + LAST_W + SEL_W;

    sw_state_e        state_q, state_d;
    logic [SEL_W-1:0] lock_in_q, lock_in_d, lock_out_q, lock_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d, err_q, err_d;

    logic              use_lock, route_legal, route_illegal;
    logic [SEL_W-1:0]  in_sel, out_sel, head_out;
    logic [NUM_IN-1:0] in_onehot, s_tready;
    logic [DATA_W-1:0] sel_data;
    logic [LAST_W-1:0] sel_last;
    logic              sel_valid, skid_ready, accept, eop;
    logic [SKID_W-1:0] head;
    logic              head_valid, head_ready;
    logic [NUM_OUT-1:0] m_tvalid;

    // Route selection and AND-OR input mux over one-hot enables.
    always_comb begin
        use_lock      = (PKT_MODE != 0) && (state_q == LOCKED);
        in_sel        = use_lock ? lock_in_q  : bus.ctrl_in_sel;
        out_sel       = use_lock ? lock_out_q : bus.ctrl_out_sel;
        route_legal   = sel_legal(in_sel, NUM_IN) && sel_legal(out_sel, NUM_OUT);
        route_illegal = !use_lock && ((32'(in_sel) > 32'(NUM_IN)) || (32'(out_sel) > 32'(NUM_OUT)));
        in_onehot     = '0;
        sel_data      = '0;
        sel_last      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_onehot[k] = route_legal && (32'(in_sel) == 32'(k + 1));
            sel_data     = sel_data | ({DATA_W{in_onehot[k]}} & bus.s_tdata[k*DATA_W +: DATA_W]);
            sel_last     = sel_last | ({LAST_W{in_onehot[k]}} & bus.s_tlast[k*LAST_W +: LAST_W]);
        end
        sel_valid = |(in_onehot & bus.s_tvalid);
        s_tready  = in_onehot & {NUM_IN{skid_ready}};
        accept    = sel_valid & skid_ready;
        eop       = |sel_last;
    end

    axis_skid_buffer #(.W(SKID_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({out_sel - SEL_W'(1), sel_last, sel_data}),
        .in_valid  (sel_valid),
        .in_ready  (skid_ready),
        .out_data  (head),
        .out_valid (head_valid),
        .out_ready (head_ready)
    );

    // The destination tag rides with each beat, so buffered data never follows a route change.
    always_comb begin
        head_out = head[SKID_W-1 -: SEL_W];
        m_tvalid = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            m_tvalid[j] = head_valid && (32'(head_out) == 32'(j));
        end
        head_ready = |(m_tvalid & bus.m_tready);
    end

    always_comb begin
        state_d    = state_q;
        lock_in_d  = lock_in_q;
        lock_out_d = lock_out_q;
        if ((PKT_MODE != 0) && accept) begin
            if (state_q == IDLE) begin
                if (!eop) begin
                    state_d    = LOCKED;
                    lock_in_d  = in_sel;
                    lock_out_d = out_sel;
                end
            end else if (eop) begin
                state_d = IDLE;
            end
        end
        cnt_d     = cnt_q + CNT_W'(accept);
        illegal_d = route_illegal;
        err_d     = route_illegal && !illegal_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_in_q  <= '0;
            lock_out_q <= '0;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_in_q  <= lock_in_d;
            lock_out_q <= lock_out_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_tready   = s_tready;
    assign bus.m_tvalid   = m_tvalid;
    assign bus.m_tdata    = head[DATA_W-1:0];
    assign bus.m_tlast    = head[DATA_W +: LAST_W];
    assign bus.route_busy = (state_q == LOCKED);
    assign bus.err_sel    = err_q;
    assign bus.beat_cnt   = cnt_q;
    assign bus.beat_pulse = accept;

endmodule

// File: tb/tb_stream_route_switch.sv
// Directed bench for stream_route_switch: packet lock, backpressure, illegal
// selects, mid-packet reset, per-beat routing and counter wrap.
module tb_stream_route_switch;
    localparam int NI = 5;
    localparam int NO = 8;
    localparam int DW = 32;
    localparam int LW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_route_switch_if #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .LAST_W(LW), .CNT_W(4))  bus  ();
    stream_route_switch_if #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .LAST_W(LW), .CNT_W(16)) bus0 ();

    stream_route_switch #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .LAST_W(LW), .PKT_MODE(1), .CNT_W(4))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    stream_route_switch #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .LAST_W(LW), .PKT_MODE(0), .CNT_W(16))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    task automatic idle_inputs();
        bus.ctrl_in_sel  = '0; bus.ctrl_out_sel  = '0; bus.s_tdata  = '0; bus.s_tlast  = '0;
        bus.s_tvalid     = '0; bus.m_tready      = '0;
        bus0.ctrl_in_sel = '0; bus0.ctrl_out_sel = '0; bus0.s_tdata = '0; bus0.s_tlast = '0;
        bus0.s_tvalid    = '0; bus0.m_tready     = '0;
    endtask

    task automatic set_beat(input int lane, input logic [DW-1:0] d, input logic [LW-1:0] l);
        bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tlast = '0;
        bus.s_tvalid[lane]          = 1'b1;
        bus.s_tdata[lane*DW +: DW]  = d;
        bus.s_tlast[lane*LW +: LW]  = l;
    endtask

    task automatic do_reset();
        @(negedge clk); idle_inputs(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ctrl_in_sel = 4'd1; bus.ctrl_out_sel = 4'd1; bus.s_tvalid = '1; bus.m_tready = '1;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        vectors++;
        if ({bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.s_tready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got mv=%h md=%h ml=%h sr=%h, expected all 0",
                     bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.s_tready);
        end
        vectors++;
        if ({bus.route_busy, bus.err_sel, bus.beat_cnt, bus.beat_pulse} !== '0) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%b err=%b cnt=%0d pulse=%b, expected 0",
                     bus.route_busy, bus.err_sel, bus.beat_cnt, bus.beat_pulse);
        end
        idle_inputs(); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_packet();
        bus.ctrl_in_sel = 4'd3; bus.ctrl_out_sel = 4'd5; bus.m_tready = 8'h10;
        for (int i = 0; i < 4; i++) begin
            set_beat(2, 32'hA300_0000 + 32'(i), (i == 3) ? 12'h800 : 12'h000);
            #1;
            vectors++;
            if ({bus.s_tready, bus.beat_pulse} !== {5'b00100, 1'b1}) begin
                miscompares++;
                $display("FAIL pkt_accept%0d: got sr=%b pulse=%b, expected 00100 1", i, bus.s_tready, bus.beat_pulse);
            end
            vectors++;
            if (bus.route_busy !== (i > 0)) begin
                miscompares++;
                $display("FAIL pkt_busy%0d: got %b expected %b", i, bus.route_busy, (i > 0));
            end
            if (i > 0) begin
                vectors++;
                if ({bus.m_tvalid, bus.m_tdata} !== {8'h10, 32'hA300_0000 + 32'(i - 1)}) begin
                    miscompares++;
                    $display("FAIL pkt_out%0d: got mv=%h md=%h expected 10 %h", i, bus.m_tvalid, bus.m_tdata,
                             32'hA300_0000 + 32'(i - 1));
                end
            end
            @(negedge clk);
        end
        bus.s_tvalid = '0; #1;
        vectors++;
        if ({bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.route_busy, bus.beat_cnt} !==
            {8'h10, 32'hA300_0003, 12'h800, 1'b0, 4'd4}) begin
            miscompares++;
            $display("FAIL pkt_eop: got mv=%h md=%h ml=%h busy=%b cnt=%0d, expected 10 a3000003 800 0 4",
                     bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.route_busy, bus.beat_cnt);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.m_tvalid !== 8'h00) begin
            miscompares++;
            $display("FAIL pkt_drain: got mv=%h expected 00", bus.m_tvalid);
        end
    endtask

    task automatic test_route_lock();
        bus.m_tready = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            bus.ctrl_in_sel  = (i == 0) ? 4'd3 : 4'd1;
            bus.ctrl_out_sel = (i == 0) ? 4'd5 : 4'd2;
            bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tlast = '0;
            if (i < 4) begin
                bus.s_tvalid[2]            = 1'b1;
                bus.s_tdata[2*DW +: DW]    = 32'hB300_0000 + 32'(i);
                bus.s_tlast[2*LW +: LW]    = (i == 3) ? 12'h800 : 12'h000;
            end
            if (i >= 1) begin
                bus.s_tvalid[0]      = 1'b1;
                bus.s_tdata[0 +: DW] = 32'hB100_0000;
                bus.s_tlast[0 +: LW] = 12'h001;
            end
            #1;
            if (i >= 1) begin
                vectors++;
                if ({bus.m_tvalid, bus.m_tdata} !== {8'h10, 32'hB300_0000 + 32'(i - 1)}) begin
                    miscompares++;
                    $display("FAIL lock_out%0d: got mv=%h md=%h expected 10 %h", i, bus.m_tvalid, bus.m_tdata,
                             32'hB300_0000 + 32'(i - 1));
                end
                vectors++;
                if (bus.s_tready !== ((i < 4) ? 5'b00100 : 5'b00001)) begin
                    miscompares++;
                    $display("FAIL lock_ready%0d: got %b expected %b", i, bus.s_tready,
                             (i < 4) ? 5'b00100 : 5'b00001);
                end
            end
            @(negedge clk);
        end
        bus.s_tvalid = '0; #1;
        vectors++;
        if ({bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.beat_cnt} !== {8'h02, 32'hB100_0000, 12'h001, 4'd9}) begin
            miscompares++;
            $display("FAIL lock_newroute: got mv=%h md=%h ml=%h cnt=%0d, expected 02 b1000000 001 9",
                     bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.beat_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] rx_data [8];
        logic [LW-1:0] rx_last [8];
        int rx_n = 0;
        int src = 0;
        int low_cnt = 0;
        do_reset();
        bus.ctrl_in_sel = 4'd3; bus.ctrl_out_sel = 4'd5;
        for (int c = 0; c < 14; c++) begin
            bus.m_tready = (c >= 2 && c <= 6) ? 8'hEF : 8'h10;
            if (src < 4) set_beat(2, 32'hC300_0000 + 32'(src), (src == 3) ? 12'h800 : 12'h000);
            else bus.s_tvalid = '0;
            #1;
            if (src < 4 && !bus.s_tready[2]) low_cnt++;
            if (bus.m_tvalid[4] && bus.m_tready[4] && rx_n < 8) begin
                rx_data[rx_n] = bus.m_tdata; rx_last[rx_n] = bus.m_tlast; rx_n++;
            end
            if (c == 4) begin
                vectors++;
                if ({bus.m_tvalid, bus.m_tdata} !== {8'h10, 32'hC300_0001}) begin
                    miscompares++;
                    $display("FAIL bp_hold: got mv=%h md=%h expected 10 c3000001", bus.m_tvalid, bus.m_tdata);
                end
            end
            if (src < 4 && bus.s_tready[2]) src++;
            @(negedge clk);
        end
        vectors++;
        if (rx_n !== 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d beats expected 4", rx_n);
        end
        for (int i = 0; i < 4 && i < rx_n; i++) begin
            vectors++;
            if ({rx_data[i], rx_last[i]} !== {32'hC300_0000 + 32'(i), (i == 3) ? 12'h800 : 12'h000}) begin
                miscompares++;
                $display("FAIL bp_order%0d: got %h/%h expected %h", i, rx_data[i], rx_last[i], 32'hC300_0000 + 32'(i));
            end
        end
        vectors++;
        if ({low_cnt, bus.beat_cnt} !== {32'd5, 4'd4}) begin
            miscompares++;
            $display("FAIL bp_stall: got ready-low=%0d cnt=%0d expected 5 4", low_cnt, bus.beat_cnt);
        end
    endtask

    task automatic run_err_phase(input logic [3:0] isel, input logic [3:0] osel, input int n, input int exp_err,
                                 input string name);
        int err_n = 0;
        int busy_n = 0;
        bus.ctrl_in_sel = isel; bus.ctrl_out_sel = osel;
        for (int c = 0; c < n; c++) begin
            #1;
            if (bus.err_sel) err_n++;
            if (bus.s_tready != '0 || bus.m_tvalid != '0) busy_n++;
            @(negedge clk);
        end
        vectors++;
        if ({err_n, busy_n} !== {exp_err, 32'd0}) begin
            miscompares++;
            $display("FAIL %s: got err pulses=%0d active=%0d expected %0d 0", name, err_n, busy_n, exp_err);
        end
    endtask

    task automatic test_illegal_sel();
        do_reset();
        bus.s_tvalid = '1; bus.m_tready = '1;
        run_err_phase(4'd7, 4'd1, 10, 1, "err_in7");
        run_err_phase(4'd0, 4'd0, 3, 0, "err_idle");
        run_err_phase(4'd2, 4'd9, 5, 1, "err_out9");
        vectors++;
        if (bus.beat_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL err_cnt: got %0d expected 0", bus.beat_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.ctrl_in_sel = 4'd3; bus.ctrl_out_sel = 4'd5; bus.m_tready = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            set_beat(2, 32'hD300_0000 + 32'(i), 12'h000);
            @(negedge clk);
        end
        set_beat(2, 32'hD300_0002, 12'h000);
        rst_n = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if ({bus.m_tvalid, bus.beat_cnt, bus.route_busy} !== {8'h00, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid: got mv=%h cnt=%0d busy=%b expected 00 0 0", bus.m_tvalid, bus.beat_cnt, bus.route_busy);
        end
        rst_n = 1'b1;
        bus.ctrl_in_sel = 4'd1; bus.ctrl_out_sel = 4'd2;
        set_beat(0, 32'hD100_0000, 12'h800);
        @(negedge clk); #1;
        vectors++;
        if (bus.s_tready !== 5'b00001) begin
            miscompares++;
            $display("FAIL rst_newroute_ready: got %b expected 00001", bus.s_tready);
        end
        @(negedge clk);
        bus.s_tvalid = '0; #1;
        vectors++;
        if ({bus.m_tvalid, bus.m_tdata, bus.beat_cnt} !== {8'h02, 32'hD100_0000, 4'd1}) begin
            miscompares++;
            $display("FAIL rst_newroute_out: got mv=%h md=%h cnt=%0d expected 02 d1000000 1",
                     bus.m_tvalid, bus.m_tdata, bus.beat_cnt);
        end
    endtask

    task automatic test_beat_mode();
        do_reset();
        bus0.m_tready = 8'hFF;
        bus0.ctrl_in_sel = 4'd3;
        for (int i = 0; i < 6; i++) begin
            bus0.ctrl_out_sel = (i % 2 == 1) ? 4'd2 : 4'd1;
            bus0.s_tvalid = 5'b00100;
            bus0.s_tdata[2*DW +: DW] = 32'hE300_0000 + 32'(i);
            #1;
            vectors++;
            if (bus0.s_tready !== 5'b00100) begin
                miscompares++;
                $display("FAIL beat_ready%0d: got %b expected 00100", i, bus0.s_tready);
            end
            if (i > 0) begin
                vectors++;
                if ({bus0.m_tvalid, bus0.m_tdata} !== {((i - 1) % 2 == 1) ? 8'h02 : 8'h01, 32'hE300_0000 + 32'(i - 1)}) begin
                    miscompares++;
                    $display("FAIL beat_out%0d: got mv=%h md=%h", i, bus0.m_tvalid, bus0.m_tdata);
                end
            end
            @(negedge clk);
        end
        bus0.s_tvalid = '0; #1;
        vectors++;
        if ({bus0.m_tvalid, bus0.m_tdata, bus0.route_busy, bus0.beat_cnt} !== {8'h02, 32'hE300_0005, 1'b0, 16'd6}) begin
            miscompares++;
            $display("FAIL beat_last: got mv=%h md=%h busy=%b cnt=%0d expected 02 e3000005 0 6",
                     bus0.m_tvalid, bus0.m_tdata, bus0.route_busy, bus0.beat_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        bus.ctrl_in_sel = 4'd1; bus.ctrl_out_sel = 4'd1; bus.m_tready = 8'hFF;
        for (int i = 0; i < 17; i++) begin
            set_beat(0, 32'(i), 12'h001);
            #1;
            if (i == 15 || i == 16) begin
                vectors++;
                if (bus.beat_cnt !== ((i == 15) ? 4'd15 : 4'd0)) begin
                    miscompares++;
                    $display("FAIL wrap%0d: got %0d expected %0d", i, bus.beat_cnt, (i == 15) ? 15 : 0);
                end
            end
            @(negedge clk);
        end
        bus.s_tvalid = '0; #1;
        vectors++;
        if ({bus.beat_cnt, bus.route_busy, bus.m_tvalid, bus.m_tdata} !== {4'd1, 1'b0, 8'h01, 32'd16}) begin
            miscompares++;
            $display("FAIL wrap_end: got cnt=%0d busy=%b mv=%h md=%h expected 1 0 01 10",
                     bus.beat_cnt, bus.route_busy, bus.m_tvalid, bus.m_tdata);
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_route_lock();
        test_backpressure();
        test_illegal_sel();
        test_reset_mid_packet();
        test_beat_mode();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
